// File: rtl/stack_pkg.sv
// Shared stack definitions: controller FSM states and default geometry
// reused by the controller and stack_memory instantiations.
package stack_pkg;

    localparam int STACK_DEPTH = 1024;
    localparam int STACK_AW    = 10;
    localparam int STACK_DW    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_CAPTURE,
        ST_FIN
    } stack_state_t;

endpackage

// File: rtl/stack_controller.sv
// Single-request stack sequencer in front of stack_memory: owns the stack
// pointer, issues push/pop strobes and captures popped words.
module stack_controller
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = STACK_AW,
    parameter int DW    = STACK_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [DW-1:0] push_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] pop_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [31:0]   stack_pointer,
    output logic          push,
    output logic          pop,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    stack_state_t  state_reg, state_next;
    logic [AW:0]   sp_reg, sp_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [DW-1:0] pop_data_reg, pop_data_next;
    logic          err_reg, err_next;
    logic [AW:0]   addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sp_reg       <= '0;
            wdata_reg    <= '0;
            pop_data_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sp_reg       <= sp_next;
            wdata_reg    <= wdata_next;
            pop_data_reg <= pop_data_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sp_next       = sp_reg;
        wdata_next    = wdata_reg;
        pop_data_next = pop_data_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                // Conflicting requests, overflow and underflow all complete
                // immediately with an error and leave sp untouched.
                if ((push_req && pop_req) || (push_req && full) || (pop_req && empty)) begin
                    err_next   = 1'b1;
                    state_next = ST_FIN;
                end else if (push_req) begin
                    err_next   = 1'b0;
                    wdata_next = push_data;
                    state_next = ST_PUSH;
                end else if (pop_req) begin
                    err_next   = 1'b0;
                    state_next = ST_POP;
                end
            end
            ST_PUSH: begin
                sp_next    = sp_reg + (AW+1)'(1);
                state_next = ST_FIN;
            end
            ST_POP: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pop_data_next = mem_rdata;
                sp_next       = sp_reg - (AW+1)'(1);
                state_next    = ST_FIN;
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes and address decode purely from registered state, so a reset
    // drops them in the same instant it clears the state register.
    assign push  = (state_reg == ST_PUSH);
    assign pop   = (state_reg == ST_POP) || (state_reg == ST_CAPTURE);
    assign addr  = pop ? (sp_reg - (AW+1)'(1)) : sp_reg;

    assign stack_pointer = 32'(addr);
    assign mem_wdata     = wdata_reg;
    assign pop_data      = pop_data_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_FIN);
    assign error         = (state_reg == ST_FIN) && err_reg;
    assign count         = sp_reg;
    assign full          = (sp_reg == (AW+1)'(DEPTH));
    assign empty         = (sp_reg == '0);

endmodule

// File: tb/tb_stack_controller.sv
// Randomised scoreboard bench for stack_controller with a behavioural stack
// reference and a simple stack_memory stand-in.
module tb_stack_controller;
    import stack_pkg::*;

    localparam int DEPTH = STACK_DEPTH;
    localparam int AW    = STACK_AW;
    localparam int DW    = STACK_DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_req, pop_req;
    logic [DW-1:0] push_data;
    logic          busy, done, error, full, empty, push, pop;
    logic [DW-1:0] pop_data, mem_wdata, mem_rdata;
    logic [AW:0]   count;
    logic [31:0]   stack_pointer;

    stack_controller #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .busy(busy), .done(done), .error(error),
        .pop_data(pop_data), .count(count), .full(full), .empty(empty),
        .stack_pointer(stack_pointer), .push(push), .pop(pop),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stand-in with a latched read port.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (push) mem[stack_pointer[AW-1:0]] <= mem_wdata;
        if (pop)  mem_rdata <= mem[stack_pointer[AW-1:0]];
    end

    typedef struct {
        string       op;
        bit          err;
        int          lat;
        int          cnt;
        logic [31:0] pdata;
        logic [31:0] wdata;
        logic [31:0] addr;
        int          npush;
        int          npop;
        time         t0;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_stack[$];
    logic [DW-1:0] last_pop = '0;
    int            checks = 0;
    int            passed = 0;
    int            push_cnt = 0;
    int            pop_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Issue one request; the expected outcome comes from the queue model.
    task automatic do_op(input bit p, input bit q, input logic [DW-1:0] d, input bit poke);
        exp_t e;
        int   sz;
        bit   seen;
        @(negedge clk);
        push_req = p; pop_req = q; push_data = d;
        @(posedge clk);
        sz      = ref_stack.size();
        e.op    = (p && q) ? "both" : (p ? "push" : "pop");
        e.err   = (p && q) || (p && sz == DEPTH) || (q && sz == 0);
        e.t0    = $time;
        e.wdata = d;
        e.addr  = '0;
        e.npush = 0;
        e.npop  = 0;
        if (e.err) begin
            e.lat = 1;
        end else if (p) begin
            e.addr = 32'(sz);
            ref_stack.push_back(d);
            e.lat = 2;
            e.npush = 1;
        end else begin
            e.addr = 32'(sz - 1);
            last_pop = ref_stack.pop_back();
            e.lat = 3;
            e.npop = 2;
        end
        e.cnt   = ref_stack.size();
        e.pdata = last_pop;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (poke && k == 0) push_req = 1'b1;
        end
        push_req = 1'b0; pop_req = 1'b0;
        if (!seen) begin
            chk("done_timeout", 1'b0, 1'b1);
            sb.delete();
        end
    endtask

    // Monitor: strobe checks every cycle, full response check at done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (push && pop) chk("strobe_exclusive", 1'b1, 1'b0);
                if (push || pop) begin
                    if (sb.size() == 0) chk("unexpected_strobe", 1'b1, 1'b0);
                    else begin
                        chk("strobe_addr", stack_pointer, sb[0].addr);
                        if (push) chk("push_wdata", mem_wdata, sb[0].wdata);
                    end
                end
                if (push) push_cnt++;
                if (pop)  pop_cnt++;
                if (done) begin
                    if (sb.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
                    else begin
                        e = sb.pop_front();
                        chk("error", error, e.err);
                        chk("latency", int'(($time - e.t0) / 10) + 1, e.lat);
                        chk("count", count, e.cnt);
                        chk("full", full, e.cnt == DEPTH);
                        chk("empty", empty, e.cnt == 0);
                        chk("pop_data", pop_data, e.pdata);
                        chk("busy_at_done", busy, 1'b1);
                        chk("push_strobes", push_cnt, e.npush);
                        chk("pop_strobes", pop_cnt, e.npop);
                        $display("txn %s err=%0d count=%0d pop_data=%h", e.op, error, count, pop_data);
                    end
                    push_cnt = 0;
                    pop_cnt  = 0;
                end
            end
        end
    end

    initial begin
        int r;
        push_req = 0; pop_req = 0; push_data = '0;
        reset = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_strobes", {push, pop}, 2'b00);
        chk("rst_sp", stack_pointer, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pop_data", pop_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_op(1, 0, 32'hDEADBEEF, 0);
        do_op(0, 1, 0, 0);
        do_op(1, 0, 32'h11, 0);
        do_op(1, 0, 32'h22, 0);
        do_op(1, 0, 32'h33, 0);
        repeat (3) do_op(0, 1, 0, 0);
        do_op(0, 1, 0, 0);              // underflow
        do_op(1, 0, 32'h5, 0);
        do_op(1, 1, 32'h6, 0);          // conflicting requests
        do_op(0, 1, 0, 1);              // push_req raised while popping

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      do_op(1, 1, $urandom, 0);
            else if (r < 6)  do_op(1, 0, $urandom, 0);
            else             do_op(0, 1, 0, (r == 9));
        end

        while (ref_stack.size() > 0) do_op(0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) do_op(1, 0, 32'(i), 0);
        do_op(1, 0, 32'hBAD, 0);        // overflow
        do_op(1, 1, 32'hBAD, 0);
        repeat (3) do_op(0, 1, 0, 0);

        // Reset while the POP state is active aborts the request.
        @(negedge clk);
        pop_req = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_before_reset", pop, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_pop", pop, 1'b0);
        chk("abort_push", push, 1'b0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pop_data", pop_data, 0);
        chk("abort_sp", stack_pointer, 0);
        pop_req = 1'b0;
        sb.delete();
        ref_stack.delete();
        last_pop = '0;
        push_cnt = 0;
        pop_cnt  = 0;
        @(negedge clk);
        reset = 1'b0;
        do_op(1, 0, 32'hCAFEF00D, 0);
        do_op(0, 1, 0, 0);
        do_op(0, 1, 0, 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencing stage directly upstream of `stack_memory`. It accepts single-word push/pop requests from the multi-cycle control unit for CALL/RET and owns the stack-pointer register. It drives the memory's `stack_pointer`/`push`/`pop`/`data_in` and captures `data_out`, reporting full/empty and overflow/underflow errors. One request is in flight at a time, with a busy/done handshake.

## Interface
- `DEPTH`, 1024: stack words; must match the `stack_memory` array size.
- `AW`, 10: pointer width; must equal log2(`DEPTH`).
- `DW`, 32: data width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push_req`  in  1  request to push `push_data`; sampled only in IDLE.
- `pop_req`  in  1  request to pop; sampled only in IDLE.
- `push_data`  in  DW  word to push; captured on acceptance.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse when a request completes, including errored requests.
- `error`  out  1  one-cycle pulse coincident with `done` for an overflow, underflow, or illegal request.
- `pop_data`  out  DW  last popped word; held until the next successful pop.
- `count`  out  AW+1  words currently stored, range 0..`DEPTH`.
- `full`, `empty`  out  1  `count`==`DEPTH` and `count`==0, respectively.
- `stack_pointer`  out  32  to memory; zero-extended pointer.
- `push`, `pop`  out  1  to memory; write and read strobes.
- `mem_wdata`  out  DW  to memory `data_in`.
- `mem_rdata`  in  DW  from memory `data_out`.

## Operation
- Stack grows upward. `sp` (AW+1 bits, equal to `count`) always points at the next free slot.
  - Push writes `mem[sp]`, then increments `sp`.
  - Pop reads `mem[sp-1]`, then decrements `sp`.
- FSM states: IDLE, PUSH, POP, CAPTURE, FIN.
  - From IDLE, with only `push_req` and not `full`: latch `push_data` into `mem_wdata` and go to PUSH.
  - From IDLE, with only `pop_req` and not `empty`: go to POP.
  - From IDLE, with `push_req` while `full`, `pop_req` while `empty`, or both requests high: go to FIN with error set. No memory strobe is issued and `sp` is unchanged.
  - PUSH: `push`=1, `stack_pointer`=`sp`. Increment `sp` at the end of the cycle, then go to FIN.
  - POP: `pop`=1, `stack_pointer`=`sp-1`. Go to CAPTURE.
  - CAPTURE: hold `pop`=1 and `stack_pointer`=`sp-1` so the memory's latched output stays stable. Register `pop_data` <= `mem_rdata` and decrement `sp`. Go to FIN.
  - FIN: `done`=1, `error`=the latched error flag. Go to IDLE.
- Requests arriving while `busy` are ignored, not queued. The requester must hold its request until `done`, then drop it.
- In IDLE: `stack_pointer`=`sp`, `push`=`pop`=0.
- `sp` never wraps. A push at `count`==`DEPTH` and a pop at `count`==0 are the only error paths.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `sp`=0, `count`=0.
  - `empty`=1, `full`=0, `busy`=0, `done`=0, `error`=0.
  - `push`=0, `pop`=0, `stack_pointer`=0, `mem_wdata`=0, `pop_data`=0.
- A reset mid-operation aborts the request. Any strobe is deasserted in the same instant; no partial `sp` update is kept.
- Push latency, with request sampled at edge E0:
  - PUSH occupies cycle 1.
  - FIN occupies cycle 2, with `done`=1 and `count` already incremented.
- Pop latency, with request sampled at edge E0:
  - POP occupies cycle 1; CAPTURE occupies cycle 2.
  - FIN occupies cycle 3, with `done`=1, `pop_data` valid, and `count` decremented.
- Error latency: FIN in cycle 1.
- `push` and `pop` are never high together. Each strobe is registered-state decoded and glitch-free relative to `clk`.
- Back-to-back operation: a new request can be accepted in the cycle after FIN, i.e. in IDLE. Minimum spacing is 3 cycles for push and 4 for pop.

## Structure
- Shared package `stack_pkg`:
  - state enum (IDLE, PUSH, POP, CAPTURE, FIN);
  - `STACK_DEPTH`=1024, `STACK_AW`=10, `STACK_DW`=32, reused by `stack_memory` instantiations.
- No sub-module. The FSM, pointer counter and capture register stay in one module.
- `full`, `empty` and `count` are decoded directly from `sp`.

## Test plan
- Reset then push 0xDEADBEEF: `push` high one cycle with `stack_pointer`=0 and `mem_wdata`=0xDEADBEEF; `done` 2 cycles after the request; `count`=1, `empty`=0.
- Push 0x11, 0x22, 0x33, then pop three times: `pop_data` = 0x33, 0x22, 0x11, each valid at `done` 3 cycles after its request; final `count`=0, `empty`=1.
- Pop on an empty stack: `done`=`error`=1 in cycle 1; no `pop` strobe; `count` stays 0; `pop_data` unchanged.
- Push 1024 words (values = index), then a 1025th push: `full`=1 after the 1024th; the 1025th gives `error`=1, no `push` strobe, `count`=1024.
- `push_req` and `pop_req` together in IDLE: `error` pulse, no strobes, `sp` unchanged. A `push_req` during a pop's CAPTURE is ignored (`count` unchanged).
- Assert `reset` during the POP state: `pop` drops immediately; after release `count`=0, state IDLE, `pop_data`=0.
